pc_gen: RTL and testbench

//  Parametrised fetch-address generator for the RV32 core.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/program_counter.sv | 21 ++
 rtl/pc_gen.sv | 106 ++++++++++
 tb/tb_pc_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 core widths and fetch-stage state encoding
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - architectural PC register, loads pc_next every cycle
module program_counter
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-address generator with run/halt control, epc and misaligned-target trap
module pc_gen
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              IALIGN    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);

    pc_state_e       state;
    pc_state_e       state_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc_next;
    logic            misaligned_next;
    logic            target_misaligned;
    logic [XLEN-1:0] pc_aligned;

    program_counter #(
        .RESET_VEC (RESET_VEC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc_next (pc_next),
        .pc      (pc_o)
    );

    assign pc_plus_o         = pc_o + STEP;
    assign fetch_valid_o     = (state == PC_RUN);
    assign target_misaligned = |(redirect_target_i & ALIGN_MASK);
    // epc low bits are forced to zero so mret can never return to a misaligned PC
    assign pc_aligned        = pc_o & ~ALIGN_MASK;

    always_comb begin
        state_next      = state;
        pc_next         = pc_o;
        epc_next        = epc_o;
        misaligned_next = 1'b0;
        case (state)
            PC_BOOT: begin
                state_next = PC_RUN;
            end
            PC_RUN: begin
                if (trap_i) begin
                    pc_next  = TRAP_VEC;
                    epc_next = pc_aligned;
                end else if (mret_i) begin
                    pc_next = epc_o;
                end else if (redirect_i && !target_misaligned) begin
                    pc_next = redirect_target_i;
                end else if (redirect_i) begin
                    pc_next         = TRAP_VEC;
                    epc_next        = pc_aligned;
                    misaligned_next = 1'b1;
                end else if (!stall_i) begin
                    pc_next = pc_plus_o;
                end
                if (halt_i && !trap_i) begin
                    state_next = PC_HALT;
                end
            end
            PC_HALT: begin
                if (trap_i) begin
                    pc_next    = TRAP_VEC;
                    epc_next   = pc_aligned;
                    state_next = PC_RUN;
                end else if (resume_i) begin
                    state_next = PC_RUN;
                end
            end
            default: begin
                state_next = PC_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PC_BOOT;
            epc_o        <= '0;
            misaligned_o <= 1'b0;
        end else begin
            state        <= state_next;
            epc_o        <= epc_next;
            misaligned_o <= misaligned_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized self-checking bench for pc_gen at IALIGN 4 and 2
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        trap_i;
    logic        mret_i;
    logic        halt_i;
    logic        resume_i;

    logic [31:0] pc0, pcp0, epc0, pc1, pcp1, epc1;
    logic        fv0, mis0, fv1, mis1;

    int checks   = 0;
    int failures = 0;

    pc_gen #(.IALIGN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(redirect_target_i), .trap_i(trap_i), .mret_i(mret_i),
        .halt_i(halt_i), .resume_i(resume_i), .pc_o(pc0), .pc_plus_o(pcp0),
        .fetch_valid_o(fv0), .epc_o(epc0), .misaligned_o(mis0)
    );

    pc_gen #(.IALIGN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(redirect_target_i), .trap_i(trap_i), .mret_i(mret_i),
        .halt_i(halt_i), .resume_i(resume_i), .pc_o(pc1), .pc_plus_o(pcp1),
        .fetch_valid_o(fv1), .epc_o(epc1), .misaligned_o(mis1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted
    int          m_mode [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_epc  [2];
    logic        m_mis  [2];
    int          m_ia   [2] = '{4, 2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_pc[k]   = 32'h0;
            m_epc[k]  = 32'h0;
            m_mis[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_mis[k] = 1'b0;
            if (m_mode[k] == 0) begin
                m_mode[k] = 1;
            end else if (m_mode[k] == 2) begin
                if (trap_i) begin
                    m_epc[k]  = m_pc[k];
                    m_pc[k]   = 32'h100;
                    m_mode[k] = 1;
                end else if (resume_i) begin
                    m_mode[k] = 1;
                end
            end else begin
                if (trap_i) begin
                    m_epc[k] = m_pc[k];
                    m_pc[k]  = 32'h100;
                end else if (mret_i) begin
                    m_pc[k] = m_epc[k];
                end else if (redirect_i) begin
                    if (redirect_target_i % m_ia[k] == 0) begin
                        m_pc[k] = redirect_target_i;
                    end else begin
                        m_epc[k] = m_pc[k];
                        m_pc[k]  = 32'h100;
                        m_mis[k] = 1'b1;
                    end
                end else if (!stall_i) begin
                    m_pc[k] = 32'(m_pc[k] + m_ia[k]);
                end
                if (halt_i && !trap_i) m_mode[k] = 2;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/pc4"},   pc0,  m_pc[0]);
        check({tag, "/plus4"}, pcp0, 32'(m_pc[0] + 4));
        check({tag, "/fv4"},   {31'b0, fv0}, {31'b0, m_mode[0] == 1});
        check({tag, "/epc4"},  epc0, m_epc[0]);
        check({tag, "/mis4"},  {31'b0, mis0}, {31'b0, m_mis[0]});
        check({tag, "/pc2"},   pc1,  m_pc[1]);
        check({tag, "/plus2"}, pcp1, 32'(m_pc[1] + 2));
        check({tag, "/fv2"},   {31'b0, fv1}, {31'b0, m_mode[1] == 1});
        check({tag, "/epc2"},  epc1, m_epc[1]);
        check({tag, "/mis2"},  {31'b0, mis1}, {31'b0, m_mis[1]});
    endtask

    task automatic idle_inputs();
        stall_i = 0; redirect_i = 0; redirect_target_i = 0;
        trap_i = 0; mret_i = 0; halt_i = 0; resume_i = 0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        check("reset_pc_const", pc0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step("boot");
        check("boot_fv", {31'b0, fv0}, 32'h1);
        check("boot_pc", pc0, 32'h0);
        step("seq4");
        check("seq_pc4", pc0, 32'h4);
        step("seq8");
        redirect_i = 1; redirect_target_i = 32'h40;
        step("redir40");
        check("redir_pc40", pc0, 32'h40);
        step("after40");
        for (int i = 0; i < 3; i++) begin
            stall_i = 1;
            step("stall");
            check("stall_hold", pc0, 32'h44);
        end
        trap_i = 1;
        step("trap");
        check("trap_pc", pc0, 32'h100);
        check("trap_epc", epc0, 32'h44);
        step("post_trap");
        mret_i = 1;
        step("mret");
        check("mret_pc", pc0, 32'h44);
        redirect_i = 1; redirect_target_i = 32'h42;
        step("misalign");
        check("mis_pc4", pc0, 32'h100);
        check("mis_pulse", {31'b0, mis0}, 32'h1);
        check("mis_ok2", pc1, 32'h42);
        step("mis_clear");
        check("mis_low", {31'b0, mis0}, 32'h0);
        redirect_i = 1; redirect_target_i = 32'h10; halt_i = 1;
        step("halt");
        check("halt_fv", {31'b0, fv0}, 32'h0);
        redirect_i = 1; redirect_target_i = 32'h80;
        step("halt_redir");
        check("halt_hold", pc0, 32'h10);
        resume_i = 1;
        step("resume");
        check("resume_pc", pc0, 32'h10);
        step("resume_seq");
        check("resume_pc14", pc0, 32'h14);
        redirect_i = 1; redirect_target_i = 32'hFFFF_FFFC;
        step("to_top");
        step("wrap");
        check("wrap_pc", pc0, 32'h0);
        halt_i = 1;
        step("halt2");
        step("halted");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_in_halt");
        check("rst_halt_fv", {31'b0, fv0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            stall_i  = ($urandom_range(0, 3) == 0);
            trap_i   = (r < 4);
            mret_i   = (r >= 4 && r < 10);
            halt_i   = ($urandom_range(0, 19) == 0);
            resume_i = ($urandom_range(0, 3) == 0);
            redirect_i = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: redirect_target_i = $urandom;
                1: redirect_target_i = 32'hFFFF_FFF0 | ($urandom & 32'hE);
                default: redirect_target_i = $urandom & 32'h0000_0FFE;
            endcase
            step("rand");
            if (i % 500 == 499) begin
                #3;
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all("rand_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
